// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg
// Shared definitions for the ALU sequencer slice:
//   - default sizing constants (register count, index width, opcode width)
//   - opcodes understood by the bus ALU (AND, OR, NOT)
//   - FSM state encoding (2-bit binary)
//   - is_legal_op(): true for the opcodes this sequencer is able to run
package alu_seq_pkg;

  localparam int SEQ_NUM_REGS  = 16;
  localparam int SEQ_REG_IDX_W = 4;
  localparam int SEQ_OPCODE_W  = 4;

  localparam logic [SEQ_OPCODE_W-1:0] OP_AND = 4'b0000;
  localparam logic [SEQ_OPCODE_W-1:0] OP_OR  = 4'b0001;
  localparam logic [SEQ_OPCODE_W-1:0] OP_NOT = 4'b0010;

  // One micro-step per state; IDLE is the only state that samples start.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD_Y = 2'd1,
    S_EXEC   = 2'd2,
    S_WB     = 2'd3
  } state_t;

  // Anything above NOT is rejected with an illegal pulse.
  function automatic logic is_legal_op(input logic [SEQ_OPCODE_W-1:0] op);
    return (op == OP_AND) || (op == OP_OR) || (op == OP_NOT);
  endfunction

endpackage

// File: rtl/alu_sequencer_decoder.sv
// reg_onehot_decoder
// Purely combinational index-to-one-hot decoder used to build the register
// file bus strobes. With en_i low the output is all zero, so a single
// instance can both select a register and stay silent outside its micro-step.
// Ports:
//   en_i      - decoder enable; zero output when low
//   idx_i     - register index to select
//   onehot_o  - one-hot strobe vector, bit idx_i set when enabled
module reg_onehot_decoder
  import alu_seq_pkg::*;
#(
  parameter int REG_IDX_W = SEQ_REG_IDX_W,
  parameter int NUM_REGS  = SEQ_NUM_REGS
) (
  input  logic                 en_i,
  input  logic [REG_IDX_W-1:0] idx_i,
  output logic [NUM_REGS-1:0]  onehot_o
);

  // Compare the index against every register position; at most one bit can
  // match, which keeps the strobe one-hot by construction.
  always_comb begin
    onehot_o = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (en_i && (idx_i == i[REG_IDX_W-1:0])) begin
        onehot_o[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer
// Multi-cycle controller that walks the bus-based ALU datapath through one
// register-to-register logic operation:
//   LOAD_Y    : source A register drives the bus, Y loads
//   EXEC      : source B register drives the bus (none for NOT), ALU runs,
//               Z loads
//   WRITEBACK : Z low half drives the bus, destination register loads
// Ports:
//   clock, clear          - rising-edge clock, async active-high reset
//   start                 - operation request, only looked at in IDLE
//   opcode                - requested ALU operation
//   ra_sel/rb_sel/rz_sel  - source A, source B, destination register indices
//   busy                  - high in every non-IDLE state
//   done                  - high for the WRITEBACK cycle
//   illegal               - one-cycle pulse after an unsupported opcode request
//   reg_out / reg_in      - one-hot register bus drive / load strobes
//   y_in, z_in, z_low_out - Y load, Z load, Z-low bus drive strobes
//   alu_op                - opcode presented to the ALU (zero outside EXEC)
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int NUM_REGS  = SEQ_NUM_REGS,
  parameter int REG_IDX_W = SEQ_REG_IDX_W,
  parameter int OPCODE_W  = SEQ_OPCODE_W
) (
  input  logic                 clock,
  input  logic                 clear,
  input  logic                 start,
  input  logic [OPCODE_W-1:0]  opcode,
  input  logic [REG_IDX_W-1:0] ra_sel,
  input  logic [REG_IDX_W-1:0] rb_sel,
  input  logic [REG_IDX_W-1:0] rz_sel,
  output logic                 busy,
  output logic                 done,
  output logic                 illegal,
  output logic [NUM_REGS-1:0]  reg_out,
  output logic [NUM_REGS-1:0]  reg_in,
  output logic                 y_in,
  output logic                 z_in,
  output logic                 z_low_out,
  output logic [OPCODE_W-1:0]  alu_op
);

  state_t                 state_q;
  logic [OPCODE_W-1:0]    opcode_q;
  logic [REG_IDX_W-1:0]   ra_q;
  logic [REG_IDX_W-1:0]   rb_q;
  logic [REG_IDX_W-1:0]   rz_q;
  logic                   illegal_q;

  logic                   out_en;
  logic [REG_IDX_W-1:0]   out_idx;
  logic                   in_en;

  // Sequencer FSM. The operand fields are captured only at acceptance, so
  // anything happening on the inputs while busy cannot disturb a running
  // operation. The illegal flag is re-evaluated every edge, which makes it a
  // single-cycle pulse for a single rejected request. Clear drops everything,
  // including a start that arrives at the same time.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q   <= S_IDLE;
      opcode_q  <= '0;
      ra_q      <= '0;
      rb_q      <= '0;
      rz_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (is_legal_op(opcode)) begin
              opcode_q <= opcode;
              ra_q     <= ra_sel;
              rb_q     <= rb_sel;
              rz_q     <= rz_sel;
              state_q  <= S_LOAD_Y;
            end else begin
              illegal_q <= 1'b1;
            end
          end
        end
        S_LOAD_Y: state_q <= S_EXEC;
        S_EXEC:   state_q <= S_WB;
        S_WB:     state_q <= S_IDLE;
        default:  state_q <= S_IDLE;
      endcase
    end
  end

  // Choose which register drives the bus. Source A in LOAD_Y, source B in
  // EXEC; NOT is unary, so the bus stays undriven during its EXEC cycle.
  always_comb begin
    out_en  = 1'b0;
    out_idx = ra_q;
    case (state_q)
      S_LOAD_Y: begin
        out_en  = 1'b1;
        out_idx = ra_q;
      end
      S_EXEC: begin
        out_en  = (opcode_q != OP_NOT);
        out_idx = rb_q;
      end
      default: begin
        out_en  = 1'b0;
        out_idx = ra_q;
      end
    endcase
  end

  // Moore strobes decoded from the state register and latched fields only.
  // Z-low and the register drive live in different states, so they can never
  // collide on the bus.
  always_comb begin
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_WB);
    y_in      = (state_q == S_LOAD_Y);
    z_in      = (state_q == S_EXEC);
    z_low_out = (state_q == S_WB);
    in_en     = (state_q == S_WB);
    alu_op    = (state_q == S_EXEC) ? opcode_q : '0;
    illegal   = illegal_q;
  end

  reg_onehot_decoder #(
    .REG_IDX_W (REG_IDX_W),
    .NUM_REGS  (NUM_REGS)
  ) u_out_dec (
    .en_i     (out_en),
    .idx_i    (out_idx),
    .onehot_o (reg_out)
  );

  reg_onehot_decoder #(
    .REG_IDX_W (REG_IDX_W),
    .NUM_REGS  (NUM_REGS)
  ) u_in_dec (
    .en_i     (in_en),
    .idx_i    (rz_q),
    .onehot_o (reg_in)
  );

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer
// Directed bench for alu_sequencer. Each accepted request pushes the
// per-cycle output vectors it should produce onto a queue; every clock the
// oldest vector is popped (an all-idle vector when the queue is empty) and
// compared with the sampled DUT outputs.
module tb_alu_sequencer;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        illegal;
    logic        yIn;
    logic        zIn;
    logic        zLowOut;
    logic [3:0]  aluOp;
    logic [15:0] regOut;
    logic [15:0] regIn;
  } outVec_t;

  logic        clock = 1'b0;
  logic        clear;
  logic        start;
  logic [3:0]  opcode;
  logic [3:0]  raSel;
  logic [3:0]  rbSel;
  logic [3:0]  rzSel;
  logic        busy;
  logic        done;
  logic        illegal;
  logic [15:0] regOut;
  logic [15:0] regIn;
  logic        yIn;
  logic        zIn;
  logic        zLowOut;
  logic [3:0]  aluOp;

  outVec_t     obs;
  outVec_t     expQ[$];
  int          doneCycles[$];
  int          compared   = 0;
  int          mismatched = 0;
  int          cycleNo    = 0;
  logic        curIdle    = 1'b1;

  alu_sequencer dut (
    .clock     (clock),
    .clear     (clear),
    .start     (start),
    .opcode    (opcode),
    .ra_sel    (raSel),
    .rb_sel    (rbSel),
    .rz_sel    (rzSel),
    .busy      (busy),
    .done      (done),
    .illegal   (illegal),
    .reg_out   (regOut),
    .reg_in    (regIn),
    .y_in      (yIn),
    .z_in      (zIn),
    .z_low_out (zLowOut),
    .alu_op    (aluOp)
  );

  always #5 clock = ~clock;

  assign obs = {busy, done, illegal, yIn, zIn, zLowOut, aluOp, regOut, regIn};

  // Compare the sampled outputs against one expected vector.
  task automatic checkOutput(input string tag, input outVec_t exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s (cycle %0d): observed %h expected %h", tag, cycleNo, obs, exp);
    end
  endtask

  // Drive request inputs; if the bench model says the sequencer is idle and a
  // start is being presented, queue the vectors that request should produce.
  task automatic applyStimulus(input logic st, input logic [3:0] op,
                               input logic [3:0] a, input logic [3:0] b,
                               input logic [3:0] z);
    outVec_t v;
    start  = st;
    opcode = op;
    raSel  = a;
    rbSel  = b;
    rzSel  = z;
    if (st && curIdle && !clear) begin
      if (op <= 4'd2) begin
        v = '0; v.busy = 1'b1; v.yIn = 1'b1; v.regOut = 16'(1) << a;
        expQ.push_back(v);
        v = '0; v.busy = 1'b1; v.zIn = 1'b1; v.aluOp = op;
        v.regOut = (op == 4'd2) ? 16'h0000 : (16'(1) << b);
        expQ.push_back(v);
        v = '0; v.busy = 1'b1; v.done = 1'b1; v.zLowOut = 1'b1; v.regIn = 16'(1) << z;
        expQ.push_back(v);
      end else begin
        v = '0; v.illegal = 1'b1;
        expQ.push_back(v);
      end
    end
  endtask

  // Advance one clock, sample 1 time unit after the edge and check.
  task automatic tick(input string tag);
    outVec_t exp;
    @(posedge clock);
    #1;
    cycleNo++;
    exp = (expQ.size() > 0) ? expQ.pop_front() : outVec_t'('0);
    curIdle = !exp.busy;
    if (exp.done) doneCycles.push_back(cycleNo);
    checkOutput(tag, exp);
  endtask

  initial begin
    clear = 1'b1;
    applyStimulus(1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
    #2;
    $display("[TB] reset phase");
    checkOutput("reset_async", outVec_t'('0));
    tick("reset_hold");
    applyStimulus(1'b1, 4'd0, 4'd1, 4'd2, 4'd3);
    tick("reset_hold_start");
    clear = 1'b0;
    applyStimulus(1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
    tick("post_reset_idle");

    $display("[TB] AND r3,r5 -> r7");
    applyStimulus(1'b1, 4'd0, 4'd3, 4'd5, 4'd7);
    tick("and_load_y");
    applyStimulus(1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
    tick("and_exec");
    tick("and_wb");
    tick("and_idle");

    $display("[TB] NOT r2 -> r2");
    applyStimulus(1'b1, 4'd2, 4'd2, 4'd9, 4'd2);
    tick("not_load_y");
    applyStimulus(1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
    tick("not_exec");
    tick("not_wb");
    tick("not_idle");

    $display("[TB] illegal opcode 0111");
    applyStimulus(1'b1, 4'd7, 4'd4, 4'd5, 4'd6);
    tick("illegal_pulse");
    applyStimulus(1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
    tick("illegal_after1");
    tick("illegal_after2");

    $display("[TB] start held with changing operands");
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                    4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      tick("held_start");
    end
    applyStimulus(1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
    for (int i = 0; i < 4; i++) tick("held_drain");

    $display("[TB] clear during EXEC");
    applyStimulus(1'b1, 4'd1, 4'd4, 4'd6, 4'd8);
    tick("clr_load_y");
    applyStimulus(1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
    tick("clr_exec");
    clear = 1'b1;
    #1;
    checkOutput("clear_async", outVec_t'('0));
    expQ.delete();
    curIdle = 1'b1;
    tick("clear_hold");
    applyStimulus(1'b1, 4'd0, 4'd3, 4'd3, 4'd3);
    tick("clear_with_start");
    clear = 1'b0;
    applyStimulus(1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
    tick("clear_released");

    $display("[TB] OR r1,r1 -> r0 after clear");
    applyStimulus(1'b1, 4'd1, 4'd1, 4'd1, 4'd0);
    tick("or_load_y");
    applyStimulus(1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
    tick("or_exec");
    tick("or_wb");
    tick("or_idle");

    $display("[TB] back-to-back operations");
    doneCycles.delete();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, (i < 4) ? 4'd0 : 4'd1, 4'd15, 4'd14, 4'd13);
      tick("b2b");
    end
    applyStimulus(1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
    for (int i = 0; i < 4; i++) tick("b2b_drain");
    compared++;
    assert (doneCycles.size() == 2 && (doneCycles[1] - doneCycles[0]) == 4)
    else begin
      mismatched++;
      $error("FAIL done_spacing: observed %0d done pulses (spacing %0d) expected 2 pulses spacing 4",
             doneCycles.size(),
             (doneCycles.size() >= 2) ? (doneCycles[1] - doneCycles[0]) : -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Multi-cycle controller that sequences the bus-based ALU datapath for one register-to-register logic operation (AND, OR, NOT).
- Three micro-steps:
  - Source A: register → bus → Y.
  - Source B: register → bus; ALU operates; result → Z.
  - Z low → bus → destination register.
- Sits between the instruction/test front end and the register file, Y, Z and ALU control strobes.
- Uses a start/busy/done handshake.

Parameters:
NUM_REGS, 16, number of general registers; width of one-hot register strobes
REG_IDX_W, 4, register index width; log2(NUM_REGS)
OPCODE_W, 4, ALU opcode width

Ports:
clock  in  1  system clock, rising edge
clear  in  1  asynchronous active-high reset
start  in  1  request; sampled only in IDLE
opcode  in  OPCODE_W  requested operation
ra_sel  in  REG_IDX_W  source A register index (loaded into Y)
rb_sel  in  REG_IDX_W  source B register index (ignored for NOT)
rz_sel  in  REG_IDX_W  destination register index
busy  out  1  high whenever state != IDLE
done  out  1  high for exactly the WRITEBACK cycle
illegal  out  1  one-cycle pulse: unsupported opcode rejected
reg_out  out  NUM_REGS  one-hot: register driving the bus
reg_in  out  NUM_REGS  one-hot: register loading from the bus
y_in  out  1  Y register load enable
z_in  out  1  Z register load enable
z_low_out  out  1  Z low half drives the bus
alu_op  out  OPCODE_W  opcode presented to the ALU

Behaviour:
- Interface: one clock (clock); reset (clear) is asynchronous and active-high.
- Reset state: while clear is high, all outputs read 0, state = IDLE and latched fields are 0.
- States: IDLE, LOAD_Y, EXEC, WRITEBACK. Encoding is 2-bit binary.
- Acceptance: in IDLE, a rising edge with start=1 and a legal opcode (0000 AND, 0001 OR, 0010 NOT) does the following:
  - latches opcode, ra_sel, rb_sel and rz_sel;
  - moves to LOAD_Y.
- Illegal opcode: in IDLE with start=1 and opcode > 0010:
  - state stays IDLE;
  - illegal=1 for the next cycle only;
  - no strobes assert.
- Transitions: LOAD_Y → EXEC → WRITEBACK → IDLE, unconditional, one cycle each.
- Outputs are Moore, decoded from state and latched fields only:
  - LOAD_Y: reg_out = onehot(ra); y_in=1.
  - EXEC: reg_out = onehot(rb), or all zero for NOT; alu_op = latched opcode; z_in=1.
  - WRITEBACK: z_low_out=1; reg_in = onehot(rz); done=1.
  - IDLE: all strobes 0; alu_op = 0.
- Timing and throughput:
  - Start sampled at edge N; done is high in cycle N+3.
  - The earliest next accept is edge N+4, giving 4 cycles per operation.
- Inputs while busy: start and operand inputs are ignored. Changes to opcode or sel inputs during busy have no effect.
- Exclusivity: at most one bit of reg_out and at most one bit of reg_in is high in any cycle. reg_out and z_low_out are never high together.
- Aliasing: ra = rb = rz (any combination) is legal and sequenced unchanged.
- Clear mid-operation: immediately returns to IDLE with all strobes 0. There is no partial writeback and no done pulse.
- Clear coincident with start: clear wins; the request is dropped.

Decomposition:
- Package alu_seq_pkg holds:
  - opcode constants OP_AND=4'b0000, OP_OR=4'b0001, OP_NOT=4'b0010;
  - state encoding constants S_IDLE, S_LOAD_Y, S_EXEC, S_WB;
  - function is_legal_op.
- One combinational sub-module, reg_onehot_decoder (REG_IDX_W → NUM_REGS, with an enable input). It is instantiated for reg_out and for reg_in.

Test Plan:
- AND: start, opcode=0000, ra=3, rb=5, rz=7 → busy=1 for 3 cycles.
  - LOAD_Y: reg_out=16'h0008, y_in=1.
  - EXEC: reg_out=16'h0020, z_in=1, alu_op=0.
  - WB: reg_in=16'h0080, z_low_out=1, done=1.
  - Then IDLE.
- NOT: opcode=0010, ra=2, rb=9, rz=2 → EXEC cycle has reg_out=0, z_in=1, alu_op=2; WB reg_in=16'h0004.
- Illegal: opcode=0111 with start → illegal=1 for one cycle, busy stays 0, no strobe ever asserts.
- Ignore while busy: start held high continuously with changing opcode/sel inputs → operations accepted every 4 cycles only, each using the values latched at acceptance.
- Clear during EXEC → all outputs 0 asynchronously, no done; after release, a new OR (ra=1, rb=1, rz=0) completes normally with reg_in=16'h0001.
- Back-to-back: done cycle followed by start in the IDLE cycle → accepted; done pulses are exactly 4 cycles apart.
